// File: rtl/tdc_pkg.sv
// Shared TDC definitions: ACAM bus width, reader FSM states and timestamp field positions.
package tdc_pkg;

  localparam int unsigned c_acam_data_width = 28;

  typedef enum logic [1:0] {
    IDLE,
    RD_LOW,
    PUSH,
    RECOVER
  } t_acam_rd_state;

  // Field layout of an ACAM FIFO1 word, for the downstream decoder.
  localparam int unsigned c_channel_msb = 27;
  localparam int unsigned c_channel_lsb = 26;
  localparam int unsigned c_start_msb   = 25;
  localparam int unsigned c_start_lsb   = 18;
  localparam int unsigned c_hit_msb     = 16;
  localparam int unsigned c_hit_lsb     = 0;

endpackage

// File: rtl/acam_ts_buffer.sv
// Two-entry registered FIFO with valid/ready output; data_o/valid_o come straight from the head flop.
module acam_ts_buffer #(
  parameter int unsigned g_width = 28
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               push_i,
  input  logic [g_width-1:0] data_i,
  output logic               full_o,
  output logic [g_width-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i
);

  logic [g_width-1:0] head_q, tail_q;
  logic               head_vld_q, tail_vld_q;
  logic               pop;

  assign pop = head_vld_q & ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      case ({push_i, pop})
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; the new word goes behind any queued one.
          if (tail_vld_q) begin
            head_q <= tail_q;
            tail_q <= data_i;
          end else begin
            head_q <= data_i;
          end
        end
        2'b10: begin
          if (!head_vld_q) begin
            head_q     <= data_i;
            head_vld_q <= 1'b1;
          end else begin
            tail_q     <= data_i;
            tail_vld_q <= 1'b1;
          end
        end
        2'b01: begin
          if (tail_vld_q) head_q <= tail_q;
          head_vld_q <= tail_vld_q;
          tail_vld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign full_o  = tail_vld_q;
  assign data_o  = head_q;
  assign valid_o = head_vld_q;

endmodule

// File: rtl/acam_fifo_reader.sv
// Drains ACAM TDC-GPX FIFO1: synchronizes ef1, strobes rd_n, captures the bus and streams words out.
module acam_fifo_reader
  import tdc_pkg::*;
#(
  parameter int unsigned g_rd_low_cycles   = 3,
  parameter int unsigned g_recovery_cycles = 4,
  parameter int unsigned g_data_width      = c_acam_data_width
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic                    acam_ef1_i,
  output logic                    acam_rd_n_o,
  input  logic [g_data_width-1:0] acam_data_i,
  output logic [g_data_width-1:0] ts_data_o,
  output logic                    ts_valid_o,
  input  logic                    ts_ready_i,
  output logic [31:0]             rd_count_o,
  output logic                    busy_o
);

  localparam int unsigned CntMax = (g_rd_low_cycles > g_recovery_cycles) ?
                                   g_rd_low_cycles : g_recovery_cycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic                    ef1_meta_q, ef1_s_q;
  t_acam_rd_state          state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [g_data_width-1:0] hold_q;
  logic                    rd_n_q;
  logic [31:0]             rd_count_q;
  logic                    capture, push, buf_full;

  // Flag flops reset to "empty" so nothing is read until the pin has been seen low twice.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      ef1_meta_q <= 1'b1;
      ef1_s_q    <= 1'b1;
    end else begin
      ef1_meta_q <= acam_ef1_i;
      ef1_s_q    <= ef1_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i && !ef1_s_q && !buf_full) begin
          state_d = RD_LOW;
          cnt_d   = CntW'(g_rd_low_cycles - 1);
        end
      end
      RD_LOW: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = PUSH;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      PUSH: begin
        push    = 1'b1;
        state_d = RECOVER;
        cnt_d   = CntW'(g_recovery_cycles - 1);
      end
      RECOVER: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // rd_n is registered from the next state so the strobe is glitch-free at the pin.
  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      rd_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_n_q  <= (state_d != RD_LOW);
      if (capture) hold_q <= acam_data_i;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i)  rd_count_q <= '0;
    else if (push) rd_count_q <= rd_count_q + 32'd1;
  end

  acam_ts_buffer #(
    .g_width (g_data_width)
  ) u_buffer (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .data_i  (hold_q),
    .full_o  (buf_full),
    .data_o  (ts_data_o),
    .valid_o (ts_valid_o),
    .ready_i (ts_ready_i)
  );

  assign acam_rd_n_o = rd_n_q;
  assign rd_count_o  = rd_count_q;
  assign busy_o      = (state_q != IDLE);

endmodule
